// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: FSM state encoding and default counter width.
package pulse_meter_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_WAIT_LOW  = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// Two-flop synchronizer plus a delay flop; flags rising and falling edges of the synchronized level.
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Reset to 1 so a signal already high at reset does not produce a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high and low phase lengths of an asynchronous pulse train, in clock samples,
// and reports each completed period with a one-cycle valid strobe.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         signal_in,
    output logic [W-1:0] high_time,
    output logic [W-1:0] low_time,
    output logic [W:0]   period,
    output logic         valid,
    output logic         overflow
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic   lvl_s;
    logic   rise_s;
    logic   fall_s;
    logic   load_s;
    state_e state_q, state_d;
    logic [W-1:0] hcnt_q, hcnt_d;
    logic [W-1:0] lcnt_q, lcnt_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] high_time_q;
    logic [W-1:0] low_time_q;
    logic [W:0]   period_q;
    logic         valid_q;
    logic         overflow_q;

    sync_edge u_sync (
        .clk_i   (clock),
        .rst_i   (reset),
        .din_i   (signal_in),
        .level_o (lvl_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOW:  if (!lvl_s) state_d = ST_WAIT_RISE; else state_d = state_q;
            ST_WAIT_RISE: if (rise_s) state_d = ST_HIGH;      else state_d = state_q;
            ST_HIGH:      if (fall_s) state_d = ST_LOW;       else state_d = state_q;
            ST_LOW:       if (rise_s) state_d = ST_HIGH;      else state_d = state_q;
            default:      state_d = ST_WAIT_LOW;
        endcase
    end

    // Counters saturate; an increment attempted at the ceiling marks the period as overflowed.
    always_comb begin
        hcnt_d = hcnt_q;
        lcnt_d = lcnt_q;
        ovf_d  = ovf_q;
        load_s = 1'b0;
        case (state_q)
            ST_WAIT_RISE: begin
                if (rise_s) begin
                    hcnt_d = CNT_ONE;
                    ovf_d  = 1'b0;
                end else begin
                    hcnt_d = hcnt_q;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    lcnt_d = CNT_ONE;
                end else if (lvl_s) begin
                    if (hcnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                   hcnt_d = hcnt_q + CNT_ONE;
                end else begin
                    hcnt_d = hcnt_q;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    load_s = 1'b1;
                    hcnt_d = CNT_ONE;
                    lcnt_d = CNT_ZERO;
                    ovf_d  = 1'b0;
                end else if (!lvl_s) begin
                    if (lcnt_q == CNT_MAX) ovf_d = 1'b1;
                    else                   lcnt_d = lcnt_q + CNT_ONE;
                end else begin
                    lcnt_d = lcnt_q;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt_q      <= CNT_ZERO;
            lcnt_q      <= CNT_ZERO;
            ovf_q       <= 1'b0;
            high_time_q <= CNT_ZERO;
            low_time_q  <= CNT_ZERO;
            period_q    <= {(W+1){1'b0}};
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            ovf_q   <= ovf_d;
            valid_q <= load_s;
            if (load_s) begin
                high_time_q <= hcnt_q;
                low_time_q  <= lcnt_q;
                period_q    <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
                overflow_q  <= ovf_q;
            end
        end
    end

    assign high_time = high_time_q;
    assign low_time  = low_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Randomized and directed phase sequences against a phase-length reference model, checked by a
// cycle-stamped scoreboard on a W=8 and a W=4 instance driven by the same waveform.
module tb_pulse_meter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic signal_in = 1'b1;

    always #5 clock = ~clock;

    logic [7:0] ht8, lt8;
    logic [8:0] per8;
    logic       v8, o8;
    logic [3:0] ht4, lt4;
    logic [4:0] per4;
    logic       v4, o4;

    pulse_meter #(.W(8)) u_dut8 (
        .clock(clock), .reset(reset), .signal_in(signal_in),
        .high_time(ht8), .low_time(lt8), .period(per8), .valid(v8), .overflow(o8)
    );

    pulse_meter #(.W(4)) u_dut4 (
        .clock(clock), .reset(reset), .signal_in(signal_in),
        .high_time(ht4), .low_time(lt4), .period(per4), .valid(v4), .overflow(o4)
    );

    typedef struct {
        int ht;
        int lt;
        int per;
        int ovf;
        int cyc;
    } exp_t;

    exp_t q[2][$];
    exp_t last[2];
    int   max_c[2] = '{255, 15};
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rst_edge = 1'b0;
    bit   started = 1'b0;

    // Reference model state: lengths of the phases as driven, in clock cycles.
    bit   prev_lvl = 1'b1;
    bit   armed = 1'b0;
    bit   meas = 1'b0;
    int   hlen = 0;
    int   llen = 0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
        if (reset) started <= 1'b1;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s W=%0d cyc=%0d actual=%0d expected=%0d", nm, (i == 0) ? 8 : 4, cyc, act, expv);
        end
    endtask

    task automatic monitor(input int i, input logic v, input logic [31:0] ht, input logic [31:0] lt,
                           input logic [31:0] per, input logic o);
        exp_t e;
        if (rst_edge) last[i] = '{0, 0, 0, 0, 0};
        if (v === 1'b1) begin
            if (q[i].size() == 0) begin
                chk("unexpected_valid", i, 32'd1, 32'd0);
            end else begin
                e = q[i].pop_front();
                chk("valid_cycle", i, cyc, e.cyc);
                last[i] = e;
            end
        end else begin
            chk("valid_low", i, {31'd0, v}, 32'd0);
            if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
                e = q[i].pop_front();
                chk("missing_valid", i, cyc, e.cyc);
            end
        end
        chk("high_time", i, ht, last[i].ht);
        chk("low_time", i, lt, last[i].lt);
        chk("period", i, per, last[i].per);
        chk("overflow", i, {31'd0, o}, last[i].ovf);
    endtask

    always @(negedge clock) begin
        if (started) begin
            monitor(0, v8, ht8, lt8, per8, o8);
            monitor(1, v4, ht4, lt4, per4, o4);
        end
    end

    task automatic push_period();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.ht  = (hlen > max_c[i]) ? max_c[i] : hlen;
            e.lt  = (llen > max_c[i]) ? max_c[i] : llen;
            e.per = e.ht + e.lt;
            e.ovf = (hlen > max_c[i] || llen > max_c[i]) ? 1 : 0;
            e.cyc = cyc + 3;
            q[i].push_back(e);
        end
    endtask

    // Drive signal_in at level lvl for n clock cycles, updating the model first.
    task automatic phase(input bit lvl, input int n);
        if (lvl && !prev_lvl) begin
            if (meas && llen > 0) push_period();
            if (armed) begin
                meas = 1'b1;
                hlen = 0;
                llen = 0;
            end
        end
        if (lvl) begin
            if (meas) hlen += n;
        end else begin
            armed = 1'b1;
            if (meas) llen += n;
        end
        prev_lvl  = lvl;
        signal_in = lvl;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        armed = 1'b0;
        meas  = 1'b0;
    endtask

    initial begin
        signal_in = 1'b1;
        do_reset(3);
        // Signal high through reset: first period measured only after a full low/high/low/high.
        phase(1'b1, 3);
        repeat (2) begin
            phase(1'b0, 3);
            phase(1'b1, 3);
        end
        repeat (10) begin
            phase(1'b0, 4);
            phase(1'b1, 4);
        end
        repeat (4) begin
            phase(1'b0, 15);
            phase(1'b1, 5);
        end
        // Long high phase saturates the narrow instance, then a normal period follows.
        phase(1'b0, 2);
        phase(1'b1, 20);
        phase(1'b0, 2);
        phase(1'b1, 3);
        phase(1'b0, 3);
        phase(1'b1, 3);
        phase(1'b0, 300);
        phase(1'b1, 2);
        phase(1'b0, 2);
        phase(1'b1, 2);
        repeat (12) begin
            phase(1'b0, 1);
            phase(1'b1, 1);
        end
        // Reset pulse four cycles into a six-cycle high phase.
        phase(1'b0, 6);
        phase(1'b1, 4);
        do_reset(1);
        phase(1'b1, 1);
        repeat (3) begin
            phase(1'b0, 6);
            phase(1'b1, 6);
        end
        repeat (40) begin
            phase(1'b0, $urandom_range(1, 18));
            phase(1'b1, $urandom_range(1, 18));
        end
        phase(1'b0, 2);
        repeat (6) @(posedge clock);
        #1;
        chk("drained", 0, q[0].size(), 32'd0);
        chk("drained", 1, q[1].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
